// File: rtl/wl_afifo_rd_stream_pkg.sv
// Shared helpers for the wl_afifo read-side blocks: width math and
// parameter legality checks.
package wl_afifo_rd_stream_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  // Index width for a circular buffer; never zero so depth 1 stays legal.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/wl_afifo_rd_obuf.sv
// Circular output buffer for the async FIFO read stream: holds words that
// have returned from the RAM and presents the head as a FWFT stream.
module wl_afifo_rd_obuf
  import wl_afifo_rd_stream_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic                             rclk,
  input  logic                             rrst_b,
  input  logic                             rclr,
  input  logic                             wr_en,
  input  logic [W-1:0]                     wr_data,
  input  logic                             pop,
  output logic [W-1:0]                     dout,
  output logic                             dout_valid,
  output logic [clog2(OBUF_DEPTH+1)-1:0]   obuf_cnt
);

  localparam int unsigned CNT_W = clog2(OBUF_DEPTH + 1);
  localparam int unsigned IDX_W = idx_w(OBUF_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OBUF_DEPTH - 1);

  logic [W-1:0]     mem_q [OBUF_DEPTH];
  logic [W-1:0]     mem_d [OBUF_DEPTH];
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    if (rclr) begin
      rd_idx_d = '0;
      wr_idx_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_idx_q] = wr_data;
        wr_idx_d        = next_idx(wr_idx_q);
      end
      if (pop) begin
        rd_idx_d = next_idx(rd_idx_q);
      end
      cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge rclk or negedge rrst_b) begin
    if (!rrst_b) begin
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout       = mem_q[rd_idx_q];
  assign dout_valid = (cnt_q != '0);
  assign obuf_cnt   = cnt_q;

  a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_b)
    !(wr_en && !pop && !rclr && (cnt_q == CNT_W'(OBUF_DEPTH))));

endmodule

// File: rtl/wl_afifo_rd_stream.sv
// Read-side stream adapter for the async FIFO: issues credit-limited RAM
// reads, absorbs the read latency and presents a FWFT valid/ready stream.
module wl_afifo_rd_stream
  import wl_afifo_rd_stream_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic                             rclk,
  input  logic                             rrst_b,
  input  logic                             rclr,
  input  logic                             rempty,
  input  logic [W-1:0]                     ram_rdata,
  output logic                             re,
  output logic [W-1:0]                     dout,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [clog2(OBUF_DEPTH+1)-1:0]   obuf_cnt
);

  localparam int unsigned CRED_W = clog2(OBUF_DEPTH + RD_LAT + 1);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [CRED_W-1:0] inflight;
  logic [CRED_W-1:0] cred;
  logic              pop;

  assign pop = dout_valid & dout_ready;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CRED_W'(vld_q[i]);
    end
    cred = CRED_W'(obuf_cnt) + inflight;
  end

  // A pop frees a slot this cycle, so a read may be issued even at full credit.
  assign re = rrst_b & ~rempty & ~rclr & ((cred < CRED_W'(OBUF_DEPTH)) | pop);

  always_comb begin
    vld_d = '0;
    if (!rclr) begin
      vld_d[0] = re;
      for (int unsigned i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge rclk or negedge rrst_b) begin
    if (!rrst_b) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  wl_afifo_rd_obuf #(
    .W          (W),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .rclk       (rclk),
    .rrst_b     (rrst_b),
    .rclr       (rclr),
    .wr_en      (vld_q[RD_LAT-1]),
    .wr_data    (ram_rdata),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .obuf_cnt   (obuf_cnt)
  );

  a_rd_lat_legal: assert property (@(posedge rclk) rd_lat_ok(RD_LAT));
  a_no_read_empty: assert property (@(posedge rclk) disable iff (!rrst_b)
    re |-> !rempty);

endmodule

// File: tb/tb_wl_afifo_rd_stream.sv
// Scoreboard bench for wl_afifo_rd_stream: a queue-based FIFO/RAM model feeds
// the DUT; a monitor pops expected words whenever the consumer accepts one.
module tb_wl_afifo_rd_stream;

  logic       clk = 1'b0;
  logic       rrst_b = 1'b0;
  logic       rclr = 1'b0;

  // Instance A: RD_LAT=1, OBUF_DEPTH=2
  logic       rempty = 1'b1;
  logic [7:0] ram_rdata = '0;
  logic       re;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [1:0] obuf_cnt;

  // Instance B: RD_LAT=2, OBUF_DEPTH=3
  logic       rempty_b = 1'b1;
  logic [7:0] ram_rdata_b = '0;
  logic       re_b;
  logic [7:0] dout_b;
  logic       dout_valid_b;
  logic       dout_ready_b = 1'b1;
  logic [1:0] obuf_cnt_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_b[$];
  int         re_cyc[$];
  int         pop_cyc[$];
  bit         underflow = 1'b0;
  int         first_re_b = -1;
  int         first_v_b = -1;
  int         pops_b = 0;

  wl_afifo_rd_stream #(.W(8), .RD_LAT(1), .OBUF_DEPTH(2)) dut_a (
    .rclk(clk), .rrst_b(rrst_b), .rclr(rclr), .rempty(rempty),
    .ram_rdata(ram_rdata), .re(re), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .obuf_cnt(obuf_cnt));

  wl_afifo_rd_stream #(.W(8), .RD_LAT(2), .OBUF_DEPTH(3)) dut_b (
    .rclk(clk), .rrst_b(rrst_b), .rclr(1'b0), .rempty(rempty_b),
    .ram_rdata(ram_rdata_b), .re(re_b), .dout(dout_b), .dout_valid(dout_valid_b),
    .dout_ready(dout_ready_b), .obuf_cnt(obuf_cnt_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  // FIFO + RAM model for A: a read pops the queue head, which shows up on
  // ram_rdata one cycle later; otherwise the RAM port carries junk.
  initial begin
    bit re_s, rclr_s;
    forever begin
      @(negedge clk);
      re_s = re;
      rclr_s = rclr;
      @(posedge clk);
      #1;
      ram_rdata = 8'($urandom());
      if (!rrst_b || rclr_s) begin
        fifo_q.delete();
      end else if (re_s) begin
        if (fifo_q.size() == 0) underflow = 1'b1;
        else ram_rdata = fifo_q.pop_front();
      end
      rempty = (fifo_q.size() == 0);
    end
  end

  // Endless source for B with a two-stage RAM read pipe.
  initial begin
    bit re_s;
    logic [7:0] pipe0, pipe1, val;
    pipe0 = '0; pipe1 = '0; val = 8'h40;
    forever begin
      @(negedge clk);
      re_s = re_b;
      @(posedge clk);
      #1;
      pipe1 = pipe0;
      pipe0 = 8'($urandom());
      if (rrst_b && re_s) begin
        pipe0 = val;
        exp_b.push_back(val);
        val = val + 8'd1;
      end
      ram_rdata_b = pipe1;
    end
  end

  // Monitor A
  initial begin
    bit         prev_stall;
    logic [7:0] prev_dout;
    prev_stall = 1'b0;
    prev_dout = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rrst_b) begin
        chk("re_in_reset", int'(re), 0);
        prev_stall = 1'b0;
      end else begin
        if (re && rempty) chk("re_while_empty", 1, 0);
        if (obuf_cnt > 2) chk("obuf_cnt_max", int'(obuf_cnt), 2);
        if (dout_valid != (obuf_cnt != 0)) chk("valid_vs_cnt", int'(dout_valid), int'(obuf_cnt != 0));
        if (prev_stall) begin
          chk("stall_valid", int'(dout_valid), 1);
          chk("stall_dout", int'(dout), int'(prev_dout));
        end
        if (re) re_cyc.push_back(cyc);
        if (dout_valid && dout_ready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) chk("unexpected_word", int'(dout), -1);
          else chk("dout_order", int'(dout), int'(exp_q.pop_front()));
        end
        if (rclr) exp_q.delete();
        prev_stall = dout_valid && !dout_ready && !rclr;
        prev_dout = dout;
      end
    end
  end

  // Monitor B
  initial begin
    forever begin
      @(negedge clk);
      if (rrst_b) begin
        if (re_b && rempty_b) chk("b_re_while_empty", 1, 0);
        if (re_b && first_re_b < 0) first_re_b = cyc;
        if (dout_valid_b && first_v_b < 0) first_v_b = cyc;
        if (dout_valid_b && dout_ready_b) begin
          pops_b++;
          if (exp_b.size() == 0) chk("b_unexpected_word", int'(dout_b), -1);
          else chk("b_dout_order", int'(dout_b), int'(exp_b.pop_front()));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: reset, then idle with an empty FIFO
    repeat (3) @(negedge clk);
    tick();
    rrst_b = 1'b1;
    @(negedge clk);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_obuf_cnt", int'(obuf_cnt), 0);
    chk("rst_dout", int'(dout), 0);
    repeat (10) begin
      @(negedge clk);
      chk("idle_re", int'(re), 0);
      chk("idle_valid", int'(dout_valid), 0);
    end

    // 2: three words, consumer always ready
    tick();
    re_cyc.delete(); pop_cyc.delete();
    dout_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (10) tick();
    chk("t2_re_count", re_cyc.size(), 3);
    chk("t2_pop_count", pop_cyc.size(), 3);
    if (re_cyc.size() == 3 && pop_cyc.size() == 3) begin
      chk("t2_re_consecutive", re_cyc[2] - re_cyc[0], 2);
      chk("t2_first_latency", pop_cyc[0] - re_cyc[0], 2);
      chk("t2_pop_consecutive", pop_cyc[2] - pop_cyc[0], 2);
    end

    // 3: same words, consumer stalled, then released
    re_cyc.delete(); pop_cyc.delete();
    dout_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (8) tick();
    @(negedge clk);
    chk("t3_re_count", re_cyc.size(), 2);
    chk("t3_obuf_cnt", int'(obuf_cnt), 2);
    chk("t3_dout_head", int'(dout), 8'h11);
    tick();
    dout_ready = 1'b1;
    repeat (8) tick();
    chk("t3_pop_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) chk("t3_no_gap", pop_cyc[2] - pop_cyc[0], 2);
    chk("t3_re_total", re_cyc.size(), 3);

    // 4: 16 random words, random backpressure
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) push(8'($urandom()));
    n = 0;
    while ((exp_q.size() != 0) && (n < 400)) begin
      tick();
      dout_ready = $urandom_range(0, 1) == 1;
      n++;
    end
    dout_ready = 1'b0;
    repeat (3) tick();
    chk("t4_drained", int'(n < 400), 1);
    chk("t4_pop_count", pop_cyc.size(), 16);

    // 5: flush with one word buffered and one in flight
    pop_cyc.delete();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    repeat (6) tick();
    @(negedge clk);
    chk("t5_full", int'(obuf_cnt), 2);
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    rclr = 1'b1;
    @(negedge clk);
    chk("t5_re_in_rclr", int'(re), 0);
    chk("t5_cnt_before_flush", int'(obuf_cnt), 1);
    tick();
    rclr = 1'b0;
    @(negedge clk);
    chk("t5_cnt_after", int'(obuf_cnt), 0);
    chk("t5_valid_after", int'(dout_valid), 0);
    tick();
    dout_ready = 1'b1;
    repeat (10) tick();
    chk("t5_pops", pop_cyc.size(), 1);
    chk("t5_underflow", int'(underflow), 0);

    // 6: RD_LAT=2, OBUF_DEPTH=3 streaming
    rempty_b = 1'b0;
    repeat (12) tick();
    chk("t6_first_latency", first_v_b - first_re_b, 3);
    repeat (15) begin
      @(negedge clk);
      chk("t6_valid_steady", int'(dout_valid_b), 1);
      chk("t6_re_steady", int'(re_b), 1);
    end
    chk("t6_pops", int'(pops_b > 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
